// File: rtl/alu_op_sequencer_if.sv
// Handshake and result bus between the control unit and the ALU op sequencer.
// master: control unit side (drives start/op/operands); slave: the sequencer.
interface alu_op_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [4:0]       op_code;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_hi;
    logic [WIDTH-1:0] result_lo;
    logic             overflow;
    logic             div_by_zero;

    modport master (
        output start, op_code, a, b,
        input  busy, done, result_hi, result_lo, overflow, div_by_zero
    );

    modport slave (
        input  start, op_code, a, b,
        output busy, done, result_hi, result_lo, overflow, div_by_zero
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU op sequencer: single-cycle ops in one step, iterative signed
// mul (shift-add) and signed restoring div, 2*WIDTH result as hi:lo.
// Optional feature macro: MUL_RADIX4_EN -> mul uses radix-4 Booth, 2 bits/edge.
module alu_op_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic              clock,
    input  logic              clear,
    alu_op_sequencer_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
`ifdef MUL_RADIX4_EN
    // Two guard bits keep Booth partial sums (up to +/-2*mcand) signed-exact.
    localparam int              ACC_W     = WIDTH + 2;
    localparam logic [CW-1:0]   MUL_STEPS = CW'(WIDTH / 2);
`else
    localparam int              ACC_W     = WIDTH;
    localparam logic [CW-1:0]   MUL_STEPS = CW'(WIDTH);
`endif
    localparam logic [CW-1:0]    DIV_STEPS = CW'(WIDTH);
    localparam logic [WIDTH-1:0] W_VEC     = WIDTH'(WIDTH);
    localparam logic [WIDTH-1:0] S_MIN     = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB = 5'b00100, OP_AND = 5'b00101,
                           OP_OR   = 5'b00110, OP_SHR = 5'b00111, OP_SHRA = 5'b01000,
                           OP_SHL  = 5'b01001, OP_ROR = 5'b01010, OP_ROL = 5'b01011,
                           OP_MUL  = 5'b01111, OP_DIV = 5'b10000, OP_NEG = 5'b10001,
                           OP_NOT  = 5'b10010;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DIV} state_t;

    state_t             state_q, state_d;
    logic [4:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [ACC_W-1:0]   acc_q, acc_d;      // mul: running high half; div: partial remainder
    logic [WIDTH-1:0]   lo_q, lo_d;        // mul: multiplier/low product; div: dividend/quotient
    logic [WIDTH-1:0]   mag_q, mag_d;      // multiplicand or divisor
    logic               neg_q, neg_d;      // product/quotient needs negating
    logic               rneg_q, rneg_d;    // remainder needs negating
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_res_q, hi_res_d, lo_res_q, lo_res_d;
    logic               ovf_q, ovf_d, dbz_q, dbz_d;

    logic [WIDTH-1:0]   abs_a, abs_b, add_r, sub_r, rot, quo_fix, rem_fix;
    logic               sh_big;
    logic [WIDTH:0]     r_sh, trial;
    logic [2*WIDTH-1:0] prod, prod_fix;

    assign abs_a  = bus.a[WIDTH-1] ? -bus.a : bus.a;
    assign abs_b  = bus.b[WIDTH-1] ? -bus.b : bus.b;
    assign add_r  = a_q + b_q;
    assign sub_r  = a_q - b_q;
    assign sh_big = (b_q >= W_VEC);
    assign rot    = b_q % W_VEC;

    // Restoring divide step: shift in next dividend bit, try subtracting divisor.
    assign r_sh  = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
    assign trial = r_sh - {1'b0, mag_q};

    assign prod     = {acc_q[WIDTH-1:0], lo_q};
    assign prod_fix = neg_q ? -prod : prod;
    assign quo_fix  = neg_q ? -lo_q : lo_q;
    assign rem_fix  = rneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

`ifdef MUL_RADIX4_EN
    logic               bprev_q, bprev_d;
    logic [ACC_W-1:0]   m_ext, pp, bsum;
    assign m_ext = {{2{mag_q[WIDTH-1]}}, mag_q};
    // Booth digit from multiplier bits {b[i+1], b[i], b[i-1]} selects the partial product.
    always_comb begin
        pp = '0;
        case ({lo_q[1:0], bprev_q})
            3'b001, 3'b010: pp = m_ext;
            3'b011:         pp = m_ext << 1;
            3'b100:         pp = -(m_ext << 1);
            3'b101, 3'b110: pp = -m_ext;
            default:        pp = '0;
        endcase
    end
    assign bsum = acc_q + pp;
`else
    logic [WIDTH:0]     mstep;
    assign mstep = {1'b0, acc_q} + {1'b0, (lo_q[0] ? mag_q : '0)};
`endif

    // Next-state and datapath: accept, iterate, then write results with a done pulse.
    always_comb begin
        state_d  = state_q;  op_d  = op_q;   a_d = a_q;     b_d = b_q;
        acc_d    = acc_q;    lo_d  = lo_q;   mag_d = mag_q; neg_d = neg_q;
        rneg_d   = rneg_q;   cnt_d = cnt_q;  done_d = 1'b0;
        hi_res_d = hi_res_q; lo_res_d = lo_res_q; ovf_d = ovf_q; dbz_d = dbz_q;
`ifdef MUL_RADIX4_EN
        bprev_d  = bprev_q;
`endif
        case (state_q)
            S_IDLE: if (bus.start) begin
                op_d  = bus.op_code;
                a_d   = bus.a;
                b_d   = bus.b;
                cnt_d = '0;
                acc_d = '0;
                if (bus.op_code == OP_MUL) begin
                    state_d = S_MUL;
`ifdef MUL_RADIX4_EN
                    // Booth works on the signed operands directly; no sign fix afterwards.
                    lo_d    = bus.b;
                    mag_d   = bus.a;
                    neg_d   = 1'b0;
                    bprev_d = 1'b0;
`else
                    lo_d  = abs_b;
                    mag_d = abs_a;
                    neg_d = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
`endif
                end else if (bus.op_code == OP_DIV && bus.b != '0) begin
                    state_d = S_DIV;
                    lo_d    = abs_a;
                    mag_d   = abs_b;
                    neg_d   = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                    rneg_d  = bus.a[WIDTH-1];
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d  = S_IDLE;
                done_d   = 1'b1;
                hi_res_d = '0;
                lo_res_d = '0;
                ovf_d    = 1'b0;
                dbz_d    = 1'b0;
                case (op_q)
                    OP_ADD: begin
                        lo_res_d = add_r;
                        ovf_d    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_r[WIDTH-1] != a_q[WIDTH-1]);
                    end
                    OP_SUB: begin
                        lo_res_d = sub_r;
                        ovf_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_r[WIDTH-1] != a_q[WIDTH-1]);
                    end
                    OP_AND:  lo_res_d = a_q & b_q;
                    OP_OR:   lo_res_d = a_q | b_q;
                    OP_SHR:  lo_res_d = sh_big ? '0 : a_q >> b_q;
                    OP_SHL:  lo_res_d = sh_big ? '0 : a_q << b_q;
                    OP_SHRA: lo_res_d = sh_big ? {WIDTH{a_q[WIDTH-1]}} : WIDTH'($signed(a_q) >>> b_q);
                    OP_ROR:  lo_res_d = (a_q >> rot) | (a_q << (W_VEC - rot));
                    OP_ROL:  lo_res_d = (a_q << rot) | (a_q >> (W_VEC - rot));
                    OP_NEG:  lo_res_d = '0 - b_q;
                    OP_NOT:  lo_res_d = ~b_q;
                    OP_DIV: begin
                        // Only reaches here with a zero divisor.
                        hi_res_d = a_q;
                        lo_res_d = '1;
                        dbz_d    = 1'b1;
                    end
                    default: lo_res_d = '0;
                endcase
            end
            S_MUL: begin
                if (cnt_q == MUL_STEPS) begin
                    state_d  = S_IDLE;
                    done_d   = 1'b1;
                    cnt_d    = '0;
                    hi_res_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_res_d = prod_fix[WIDTH-1:0];
                    ovf_d    = 1'b0;
                    dbz_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`ifdef MUL_RADIX4_EN
                    acc_d   = {{2{bsum[ACC_W-1]}}, bsum[ACC_W-1:2]};
                    lo_d    = {bsum[1:0], lo_q[WIDTH-1:2]};
                    bprev_d = lo_q[1];
`else
                    acc_d = mstep[WIDTH:1];
                    lo_d  = {mstep[0], lo_q[WIDTH-1:1]};
`endif
                end
            end
            S_DIV: begin
                if (cnt_q == DIV_STEPS) begin
                    state_d  = S_IDLE;
                    done_d   = 1'b1;
                    cnt_d    = '0;
                    hi_res_d = rem_fix;
                    lo_res_d = quo_fix;
                    ovf_d    = (a_q == S_MIN) && (b_q == '1);
                    dbz_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    acc_d = trial[WIDTH] ? ACC_W'(r_sh[WIDTH-1:0]) : ACC_W'(trial[WIDTH-1:0]);
                    lo_d  = {lo_q[WIDTH-2:0], ~trial[WIDTH]};
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; clear aborts any op and zeroes all outputs.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q  <= S_IDLE; op_q <= '0;  a_q <= '0;   b_q <= '0;
            acc_q    <= '0;     lo_q <= '0;  mag_q <= '0; neg_q <= 1'b0;
            rneg_q   <= 1'b0;   cnt_q <= '0; done_q <= 1'b0;
            hi_res_q <= '0;     lo_res_q <= '0; ovf_q <= 1'b0; dbz_q <= 1'b0;
`ifdef MUL_RADIX4_EN
            bprev_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d; op_q <= op_d;   a_q <= a_d;     b_q <= b_d;
            acc_q    <= acc_d;   lo_q <= lo_d;   mag_q <= mag_d; neg_q <= neg_d;
            rneg_q   <= rneg_d;  cnt_q <= cnt_d; done_q <= done_d;
            hi_res_q <= hi_res_d; lo_res_q <= lo_res_d; ovf_q <= ovf_d; dbz_q <= dbz_d;
`ifdef MUL_RADIX4_EN
            bprev_q  <= bprev_d;
`endif
        end
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = done_q;
    assign bus.result_hi   = hi_res_q;
    assign bus.result_lo   = lo_res_q;
    assign bus.overflow    = ovf_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed corner cases plus random
// ops against an arithmetic reference model (WIDTH = 32).
module tb_alu_op_sequencer;
    localparam int     W    = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;
`ifdef MUL_RADIX4_EN
    localparam int MUL_LAT = 17;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    localparam logic [4:0] ADD = 5'b00011, SUB = 5'b00100, AND_ = 5'b00101, OR_ = 5'b00110,
                           SHR = 5'b00111, SHRA = 5'b01000, SHL = 5'b01001, ROR = 5'b01010,
                           ROL = 5'b01011, MUL = 5'b01111, DIV = 5'b10000, NEG = 5'b10001,
                           NOT_ = 5'b10010;

    logic clock = 1'b0;
    logic clear = 1'b1;
    int   total = 0;
    int   bad   = 0;

    alu_op_sequencer_if #(.WIDTH(W)) bus ();
    alu_op_sequencer #(.WIDTH(W)) dut (.clock(clock), .clear(clear), .bus(bus));

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Reference: results straight from signed/unsigned integer arithmetic.
    function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo,
                                  output logic ov, output logic dz, output int lat);
        longint sa, sb, p, q, r;
        logic [63:0] dbl, dsh;
        int sh;
        hi = '0; lo = '0; ov = 1'b0; dz = 1'b0; lat = 1;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b % 32);
        dbl = {a, a};
        case (op)
            ADD:  begin p = sa + sb; lo = p[31:0]; ov = (p > SMAX) || (p < SMIN); end
            SUB:  begin p = sa - sb; lo = p[31:0]; ov = (p > SMAX) || (p < SMIN); end
            AND_: lo = a & b;
            OR_:  lo = a | b;
            SHR:  lo = (b >= 32) ? 32'h0 : a >> b;
            SHL:  lo = (b >= 32) ? 32'h0 : a << b;
            SHRA: begin
                p  = (b >= 32) ? (sa < 0 ? -64'sd1 : 64'sd0) : (sa >>> b);
                lo = p[31:0];
            end
            ROR:  begin dsh = dbl >> sh; lo = dsh[31:0]; end
            ROL:  begin dsh = dbl << sh; lo = dsh[63:32]; end
            MUL:  begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; lat = MUL_LAT; end
            DIV:  begin
                if (b == 0) begin
                    hi = a; lo = 32'hFFFF_FFFF; dz = 1'b1;
                end else begin
                    q = sa / sb; r = sa % sb;
                    lo = q[31:0]; hi = r[31:0];
                    ov = (sa == SMIN) && (sb == -64'sd1);
                    lat = DIV_LAT;
                end
            end
            NEG:  lo = 32'h0 - b;
            NOT_: lo = ~b;
            default: ;
        endcase
    endfunction

    // Issue one op, scramble inputs after acceptance, wait for done (bounded).
    // Returns at the negedge of the done cycle; lat = -1 on timeout.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic busy_ok);
        @(negedge clock);
        bus.start = 1'b1; bus.op_code = op; bus.a = a; bus.b = b;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0; bus.op_code = 5'($urandom); bus.a = $urandom; bus.b = $urandom;
        lat = -1; busy_ok = 1'b1;
        for (int k = 0; k <= 100; k++) begin
            if (bus.done === 1'b1) begin lat = k; break; end
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        clear = 1'b1; bus.start = 1'b0; bus.op_code = '0; bus.a = '0; bus.b = '0;
        repeat (3) @(negedge clock);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
        total++; if (bus.result_hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h want=0", bus.result_hi); end
        total++; if (bus.result_lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h want=0", bus.result_lo); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", bus.overflow); end
        total++; if (bus.div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b want=0", bus.div_by_zero); end
        clear = 1'b0;
    endtask

    task automatic test_add_overflow();
        int lat; logic bok;
        issue(ADD, 32'h7FFF_FFFF, 32'h1, lat, bok);
        total++; if (lat !== 1) begin bad++; $display("FAIL add_latency got=%0d want=1", lat); end
        total++; if (bus.result_lo !== 32'h8000_0000) begin bad++; $display("FAIL add_lo got=%h want=80000000", bus.result_lo); end
        total++; if (bus.result_hi !== 32'h0) begin bad++; $display("FAIL add_hi got=%h want=0", bus.result_hi); end
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL add_ovf got=%b want=1", bus.overflow); end
    endtask

    task automatic test_mul();
        int lat; logic bok;
        logic [31:0] hi0, lo0;
        issue(MUL, 32'hFFFF_FFFD, 32'd7, lat, bok);
        total++; if (lat !== MUL_LAT) begin bad++; $display("FAIL mul_latency got=%0d want=%0d", lat, MUL_LAT); end
        total++; if ({bus.result_hi, bus.result_lo} !== 64'hFFFF_FFFF_FFFF_FFEB)
            begin bad++; $display("FAIL mul_result got=%h%h want=ffffffffffffffeb", bus.result_hi, bus.result_lo); end
        total++; if (bok !== 1'b1) begin bad++; $display("FAIL mul_busy got=%b want=1", bok); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mul_busy_at_done got=%b want=0", bus.busy); end
        hi0 = bus.result_hi; lo0 = bus.result_lo;
        @(negedge clock);
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL done_pulse got=%b want=0", bus.done); end
        total++; if ({bus.result_hi, bus.result_lo} !== 64'hFFFF_FFFF_FFFF_FFEB)
            begin bad++; $display("FAIL result_hold got=%h%h want=%h%h", bus.result_hi, bus.result_lo, hi0, lo0); end
    endtask

    task automatic test_div();
        int lat; logic bok;
        issue(DIV, 32'hFFFF_FFF9, 32'd2, lat, bok);
        total++; if (lat !== DIV_LAT) begin bad++; $display("FAIL div_latency got=%0d want=%0d", lat, DIV_LAT); end
        total++; if (bus.result_lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_quo got=%h want=fffffffd", bus.result_lo); end
        total++; if (bus.result_hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_rem got=%h want=ffffffff", bus.result_hi); end
        issue(DIV, 32'd5, 32'd0, lat, bok);
        total++; if (lat !== 1) begin bad++; $display("FAIL div0_latency got=%0d want=1", lat); end
        total++; if (bus.div_by_zero !== 1'b1) begin bad++; $display("FAIL div0_flag got=%b want=1", bus.div_by_zero); end
        total++; if (bus.result_lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div0_lo got=%h want=ffffffff", bus.result_lo); end
        total++; if (bus.result_hi !== 32'd5) begin bad++; $display("FAIL div0_hi got=%h want=5", bus.result_hi); end
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bok);
        total++; if ({bus.result_hi, bus.result_lo, bus.overflow} !== {32'h0, 32'h8000_0000, 1'b1})
            begin bad++; $display("FAIL div_ovf got=%h/%h/%b want=0/80000000/1", bus.result_hi, bus.result_lo, bus.overflow); end
    endtask

    task automatic test_shift_rotate();
        int lat; logic bok;
        issue(ROL, 32'h8000_0001, 32'd33, lat, bok);
        total++; if (bus.result_lo !== 32'h3) begin bad++; $display("FAIL rol got=%h want=3", bus.result_lo); end
        issue(SHRA, 32'h8000_0000, 32'd40, lat, bok);
        total++; if (bus.result_lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL shra_big got=%h want=ffffffff", bus.result_lo); end
        issue(SHL, 32'h1234_5678, 32'd32, lat, bok);
        total++; if (bus.result_lo !== 32'h0) begin bad++; $display("FAIL shl_big got=%h want=0", bus.result_lo); end
    endtask

    task automatic test_random();
        logic [4:0]  ops [14] = '{ADD, SUB, AND_, OR_, SHR, SHRA, SHL, ROR, ROL, MUL, DIV, NEG, NOT_, 5'b11100};
        logic [4:0]  op;
        logic [31:0] a, b, ehi, elo;
        logic        eov, edz, bok;
        int          elat, lat;
        for (int n = 0; n < 40; n++) begin
            op = ops[$urandom_range(0, 13)];
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = $urandom_range(0, 70);
                1: b = 32'h0;
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: begin a = $urandom_range(0, 50); b = $urandom_range(1, 9); end
                4: begin a = 32'h7FFF_FFF0 + $urandom_range(0, 15); b = $urandom_range(0, 40); end
                default: ;
            endcase
            model(op, a, b, ehi, elo, eov, edz, elat);
            issue(op, a, b, lat, bok);
            total++; if (lat !== elat) begin bad++; $display("FAIL rnd_latency op=%b a=%h b=%h got=%0d want=%0d", op, a, b, lat, elat); end
            total++; if (bus.result_lo !== elo) begin bad++; $display("FAIL rnd_lo op=%b a=%h b=%h got=%h want=%h", op, a, b, bus.result_lo, elo); end
            total++; if (bus.result_hi !== ehi) begin bad++; $display("FAIL rnd_hi op=%b a=%h b=%h got=%h want=%h", op, a, b, bus.result_hi, ehi); end
            total++; if (bus.overflow !== eov) begin bad++; $display("FAIL rnd_ovf op=%b a=%h b=%h got=%b want=%b", op, a, b, bus.overflow, eov); end
            total++; if (bus.div_by_zero !== edz) begin bad++; $display("FAIL rnd_dbz op=%b a=%h b=%h got=%b want=%b", op, a, b, bus.div_by_zero, edz); end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clock);
        bus.start = 1'b1; bus.op_code = MUL; bus.a = 32'hFFFF_FFFD; bus.b = 32'd7;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        repeat (4) @(negedge clock);
        // Sampled at edge N+5 while busy: must be dropped.
        bus.start = 1'b1; bus.op_code = ADD; bus.a = 32'd1; bus.b = 32'd1;
        @(negedge clock);
        bus.start = 1'b0;
        lat = -1;
        for (int k = 5; k <= 100; k++) begin
            if (bus.done === 1'b1) begin lat = k; break; end
            @(negedge clock);
        end
        total++; if (lat !== MUL_LAT) begin bad++; $display("FAIL ignore_latency got=%0d want=%0d", lat, MUL_LAT); end
        total++; if ({bus.result_hi, bus.result_lo} !== 64'hFFFF_FFFF_FFFF_FFEB)
            begin bad++; $display("FAIL ignore_result got=%h%h want=ffffffffffffffeb", bus.result_hi, bus.result_lo); end
        // New request during the done cycle.
        bus.start = 1'b1; bus.op_code = ADD; bus.a = 32'd2; bus.b = 32'd3;
        @(negedge clock);
        bus.start = 1'b0;
        total++; if (bus.done !== 1'b0 || bus.busy !== 1'b1)
            begin bad++; $display("FAIL b2b_accept got=done%b/busy%b want=done0/busy1", bus.done, bus.busy); end
        @(negedge clock);
        total++; if (bus.done !== 1'b1 || bus.result_lo !== 32'd5)
            begin bad++; $display("FAIL b2b_result got=done%b/%h want=done1/5", bus.done, bus.result_lo); end
    endtask

    task automatic test_clear();
        int lat; logic bok, seen;
        @(negedge clock);
        bus.start = 1'b1; bus.op_code = MUL; bus.a = 32'hFFFF_FFFD; bus.b = 32'd7;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        repeat (9) @(negedge clock);
        clear = 1'b1;
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL clear_busy got=%b want=0", bus.busy); end
        total++; if ({bus.result_hi, bus.result_lo} !== 64'h0)
            begin bad++; $display("FAIL clear_result got=%h%h want=0", bus.result_hi, bus.result_lo); end
        total++; if ({bus.done, bus.overflow, bus.div_by_zero} !== 3'b000)
            begin bad++; $display("FAIL clear_flags got=%b want=000", {bus.done, bus.overflow, bus.div_by_zero}); end
        @(negedge clock);
        clear = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL clear_no_done got=%b want=0", seen); end
        issue(ADD, 32'd2, 32'd3, lat, bok);
        total++; if (lat !== 1 || bus.result_lo !== 32'd5)
            begin bad++; $display("FAIL clear_then_add got=lat%0d/%h want=lat1/5", lat, bus.result_lo); end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_mul();
        test_div();
        test_shift_rotate();
        test_random();
        test_back_to_back();
        test_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
